// File: rtl/demux2_stream.sv
// Steers one input stream into one of two independent per-channel FIFOs by select S.
// Each channel drains through its own valid/ready port; stall_cnt tracks blocked offers.
module demux2_stream #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             _E,
    input  logic             S,
    input  logic [WIDTH-1:0] I,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] Y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [7:0]       stall_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [PW-1:0]    wr_ptr [2];
    logic [PW-1:0]    rd_ptr [2];
    logic [CW-1:0]    cnt    [2];
    logic [1:0]       full;
    logic [1:0]       nonempty;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             stall;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full[c]     = (cnt[c] == CW'(DEPTH));
            nonempty[c] = (cnt[c] != '0);
        end
    end

    // Acceptance depends only on enable and the selected channel's occupancy.
    assign in_ready = !_E && !full[S];
    assign stall    = in_valid && !_E && !in_ready;

    always_comb begin
        push = 2'b00;
        if (in_valid && in_ready)
            push[S] = 1'b1;
    end

    assign pop = {nonempty[1] && y1_ready, nonempty[0] && y0_ready};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
            stall_cnt <= 8'd0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c])
                    wr_ptr[c] <= wr_ptr[c] + PW'(1);
                if (pop[c])
                    rd_ptr[c] <= rd_ptr[c] + PW'(1);
                case ({push[c], pop[c]})
                    2'b10:   cnt[c] <= cnt[c] + CW'(1);
                    2'b01:   cnt[c] <= cnt[c] - CW'(1);
                    default: cnt[c] <= cnt[c];
                endcase
            end
            if (stall)
                stall_cnt <= sat_inc8(stall_cnt);
        end
    end

    // Storage is data-only; entries are never observed until counted as occupied.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c])
                mem[c][wr_ptr[c]] <= I;
        end
    end

    assign y0_valid = nonempty[0];
    assign y1_valid = nonempty[1];
    assign Y0 = nonempty[0] ? mem[0][rd_ptr[0]] : '0;
    assign Y1 = nonempty[1] ? mem[1][rd_ptr[1]] : '0;

endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream (WIDTH=4, DEPTH=2) with immediate-assertion checks.
module tb_demux2_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       _E;
    logic       S;
    logic [3:0] I;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] Y0;
    logic       y0_valid;
    logic       y0_ready;
    logic [3:0] Y1;
    logic       y1_valid;
    logic       y1_ready;
    logic [7:0] stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    demux2_stream #(.WIDTH(4), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), ._E(_E), .S(S), .I(I),
        .in_valid(in_valid), .in_ready(in_ready),
        .Y0(Y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
        .Y1(Y1), .y1_valid(y1_valid), .y1_ready(y1_ready),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; _E = 1'b1; S = 1'bx; I = 4'bxxxx;
        in_valid = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;

        // 1: reset with X data inputs and enable off
        tick();
        chk("rst_Y0", Y0, 4'h0);
        chk("rst_Y1", Y1, 4'h0);
        chk("rst_y0_valid", y0_valid, 1'b0);
        chk("rst_y1_valid", y1_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_stall", stall_cnt, 8'd0);
        reset = 1'b0;

        // 2: one push into each channel
        _E = 1'b0; S = 1'b0; I = 4'b1010; in_valid = 1'b1;
        #1 chk("t2_ready_s0", in_ready, 1'b1);
        tick();
        chk("t2_latency_Y0", Y0, 4'hA);
        chk("t2_latency_v0", y0_valid, 1'b1);
        chk("t2_latency_v1", y1_valid, 1'b0);
        S = 1'b1; I = 4'b0101;
        #1 chk("t2_ready_s1", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t2_Y0", Y0, 4'hA);
        chk("t2_Y1", Y1, 4'h5);
        chk("t2_y0_valid", y0_valid, 1'b1);
        chk("t2_y1_valid", y1_valid, 1'b1);

        // drain both channels together
        y0_ready = 1'b1; y1_ready = 1'b1;
        tick();
        y0_ready = 1'b0; y1_ready = 1'b0;
        chk("drain_v0", y0_valid, 1'b0);
        chk("drain_v1", y1_valid, 1'b0);
        chk("drain_Y0", Y0, 4'h0);
        chk("drain_Y1", Y1, 4'h0);

        // 3: fill channel 0, then stall on it
        S = 1'b0; in_valid = 1'b1; I = 4'h1;
        tick();
        I = 4'h2;
        tick();
        I = 4'h9;
        #1 chk("t3_full_ready_s0", in_ready, 1'b0);
        S = 1'b1;
        #1 chk("t3_ready_s1", in_ready, 1'b1);
        S = 1'b0;
        tick(); tick(); tick();
        chk("t3_stall3", stall_cnt, 8'd3);
        chk("t3_Y0_head", Y0, 4'h1);
        chk("t3_y1_untouched", y1_valid, 1'b0);
        _E = 1'b1;
        #1 chk("t3_disabled_ready", in_ready, 1'b0);
        tick();
        chk("t3_disabled_nostall", stall_cnt, 8'd3);
        _E = 1'b0;

        // 4: full channel, pop and offer on the same edge -> pop only
        I = 4'h3; y0_ready = 1'b1;
        #1 chk("t4_nobypass_ready", in_ready, 1'b0);
        tick();
        y0_ready = 1'b0;
        chk("t4_pop_Y0", Y0, 4'h2);
        chk("t4_stall4", stall_cnt, 8'd4);
        #1 chk("t4_ready_after_pop", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t4_head_still2", Y0, 4'h2);
        y0_ready = 1'b1;
        tick();
        chk("t4_pop_then3", Y0, 4'h3);
        chk("t4_valid_3", y0_valid, 1'b1);
        tick();
        y0_ready = 1'b0;
        chk("t4_empty_v0", y0_valid, 1'b0);
        chk("t4_empty_Y0", Y0, 4'h0);
        tick();
        chk("t4_idle_pop_noeffect", y0_valid, 1'b0);

        // 5: simultaneous push/pop on channel 1 at occupancy 1, across pointer wrap
        S = 1'b1; I = 4'h5; in_valid = 1'b1;
        tick();
        chk("t5_prefill", Y1, 4'h5);
        y1_ready = 1'b1;
        for (int d = 6; d <= 10; d++) begin
            I = 4'(d);
            tick();
            chk($sformatf("t5_Y1_%0d", d), Y1, 32'(d));
            chk($sformatf("t5_v1_%0d", d), y1_valid, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        y1_ready = 1'b0;
        chk("t5_drained", y1_valid, 1'b0);
        chk("t5_stall_unchanged", stall_cnt, 8'd4);

        // 6: reset mid-stream, then saturate the stall counter
        S = 1'b0; I = 4'hC; in_valid = 1'b1;
        tick();
        S = 1'b1; I = 4'hD;
        tick();
        S = 1'b0; I = 4'hE; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("t6_rst_v0", y0_valid, 1'b0);
        chk("t6_rst_v1", y1_valid, 1'b0);
        chk("t6_rst_Y0", Y0, 4'h0);
        chk("t6_rst_Y1", Y1, 4'h0);
        chk("t6_rst_stall", stall_cnt, 8'd0);
        in_valid = 1'b1; I = 4'h1;
        tick();
        I = 4'h2;
        tick();
        chk("t6_full_head", Y0, 4'h1);
        for (int k = 0; k < 254; k++) tick();
        chk("t6_stall254", stall_cnt, 8'd254);
        tick();
        chk("t6_stall255", stall_cnt, 8'd255);
        for (int k = 0; k < 45; k++) tick();
        chk("t6_stall_sat", stall_cnt, 8'd255);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
